// File: rtl/sram_sdp_be.sv
// rtl/sram_sdp_be.sv - simple dual-port block RAM with byte enables, read pipeline and clear engine
module sram_sdp_be #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ce,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  output logic                    o_init_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_next;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single array write port, shared between the clear engine and user writes
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_wbe;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_acc;
  logic rd_acc;

  // First read stage: raw array word plus what is needed to fix it up afterwards
  logic                  rd_valid1;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_zero;
  logic                  byp_en;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [NB-1:0]         byp_be;
  logic [DATA_WIDTH-1:0] rd_merged;

  assign o_init_done = (state == ST_READY);
  assign wr_in_range = ({1'b0, i_waddr} < DEPTH_W);
  assign rd_in_range = ({1'b0, i_raddr} < DEPTH_W);
  assign wr_acc      = i_ce & i_we & o_init_done & wr_in_range;
  assign rd_acc      = i_ce & i_re & o_init_done;

  // State register and clear counter; reset restarts the clear from address 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and write-port steering: clear engine owns the port until READY
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_waddr  = i_waddr;
    mem_wdata  = i_wdata;
    mem_wbe    = i_wbe;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = '0;
        mem_wbe   = '1;
        cnt_next  = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_ADDR) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end
      end
      ST_READY: begin
        mem_we = wr_acc;
      end
      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  // Byte-lane array write; no reset so the array maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_wbe[k]) begin
          mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Array read register; only loaded on an in-range accepted read
  always_ff @(posedge i_clk) begin
    if (rd_acc && rd_in_range) begin
      rd_word <= mem[i_raddr];
    end
  end

  // Read stage control: valid, out-of-range zeroing and same-address bypass capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_valid1 <= 1'b0;
      rd_zero   <= 1'b1;
      byp_en    <= 1'b0;
      byp_data  <= '0;
      byp_be    <= '0;
    end else if (i_ce) begin
      rd_valid1 <= rd_acc;
      if (rd_acc) begin
        rd_zero  <= ~rd_in_range;
        byp_en   <= (RDW_MODE != 0) && wr_acc && (i_waddr == i_raddr);
        byp_data <= i_wdata;
        byp_be   <= i_wbe;
      end
    end
  end

  // Merge written bytes over the old word for write-first reads
  always_comb begin
    rd_merged = rd_word;
    if (byp_en) begin
      for (int k = 0; k < NB; k++) begin
        if (byp_be[k]) begin
          rd_merged[8*k +: 8] = byp_data[8*k +: 8];
        end
      end
    end
    if (rd_zero) begin
      rd_merged = '0;
    end
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      assign o_rdata  = rd_merged;
      assign o_rvalid = rd_valid1;
    end else begin : g_outreg
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;

      // Optional output register; data only moves when a result is present
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (i_ce) begin
          out_valid <= rd_valid1;
          if (rd_valid1) begin
            out_data <= rd_merged;
          end
        end
      end

      assign o_rdata  = out_data;
      assign o_rvalid = out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sram_sdp_be.sv
// tb/tb_sram_sdp_be.sv - scoreboard bench for sram_sdp_be, two configurations on shared stimulus
module tb_sram_sdp_be;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ce;
  logic        i_we;
  logic [7:0]  i_waddr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wbe;
  logic        i_re;
  logic [7:0]  i_raddr;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, done_a, done_b;

  always #5 i_clk = ~i_clk;

  // A: DEPTH 256, latency 1, read-first
  sram_sdp_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_wbe(i_wbe), .i_re(i_re), .i_raddr(i_raddr), .o_rdata(rdata_a), .o_rvalid(rvalid_a), .o_init_done(done_a));

  // B: DEPTH 200, latency 2, write-first
  sram_sdp_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_wbe(i_wbe), .i_re(i_re), .i_raddr(i_raddr), .o_rdata(rdata_b), .o_rvalid(rvalid_b), .o_init_done(done_b));

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model [2][256];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  bit          rdy = 1'b0;
  bit          mon_ce;
  bit          mon_rst;
  int          na, nb, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic model_step(input int d, input bit we, input int wa, input logic [31:0] wd,
                            input logic [3:0] be, input bit re, input int ra);
    int          dep;
    logic [31:0] e;
    dep = (d == 0) ? 256 : 200;
    if (re) begin
      e = (ra < dep) ? model[d][ra] : 32'h0;
      if (d == 1 && we && wa == ra && ra < dep) e = merge(e, wd, be);
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    if (we && wa < dep) model[d][wa] = merge(model[d][wa], wd, be);
  endtask

  task automatic drive(input bit ce, input bit we, input int wa, input logic [31:0] wd,
                       input logic [3:0] be, input bit re, input int ra);
    @(negedge i_clk);
    i_ce = ce; i_we = we; i_waddr = 8'(wa); i_wdata = wd; i_wbe = be; i_re = re; i_raddr = 8'(ra);
    if (ce && rdy) begin
      model_step(0, we, wa, wd, be, re, ra);
      model_step(1, we, wa, wd, be, re, ra);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0);
  endtask

  // Output monitor: pop one expected result per valid on every edge that advanced the pipeline
  always @(posedge i_clk) begin
    mon_ce  = i_ce;
    mon_rst = i_rst;
    #1;
    if (!mon_rst && !i_rst && mon_ce) begin
      if (rvalid_a) begin
        if (qa.size() == 0) chk("unexpected_rvalid_a", {31'b0, rvalid_a}, 32'h0);
        else begin last_a = qa.pop_front(); chk("rdata_a", rdata_a, last_a); end
      end
      if (rvalid_b) begin
        if (qb.size() == 0) chk("unexpected_rvalid_b", {31'b0, rvalid_b}, 32'h0);
        else begin last_b = qb.pop_front(); chk("rdata_b", rdata_b, last_b); end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin model[0][i] = '0; model[1][i] = '0; end
    i_rst = 1'b1; i_ce = 1'b1; i_we = 1'b0; i_waddr = '0; i_wdata = '0; i_wbe = '0; i_re = 1'b0; i_raddr = '0;

    // reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_rdata_a", rdata_a, 32'h0);
    chk("rst_rdata_b", rdata_b, 32'h0);
    chk("rst_rvalid_a", {31'b0, rvalid_a}, 32'h0);
    chk("rst_rvalid_b", {31'b0, rvalid_b}, 32'h0);
    chk("rst_done_a", {31'b0, done_a}, 32'h0);
    chk("rst_done_b", {31'b0, done_b}, 32'h0);

    // reset again at cnt = 100 mid-clear
    @(negedge i_clk) i_rst = 1'b0;
    repeat (100) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("midclear_done_a", {31'b0, done_a}, 32'h0);
    chk("midclear_rvalid_a", {31'b0, rvalid_a}, 32'h0);
    @(negedge i_clk) i_rst = 1'b0;

    // count clear cycles; a request issued during clear must be ignored
    n = 0; na = 0; nb = 0;
    while (n < 400 && (na == 0 || nb == 0)) begin
      @(posedge i_clk);
      #1;
      n++;
      if (na == 0 && done_a) na = n;
      if (nb == 0 && done_b) nb = n;
      if (n == 49) begin i_re = 1'b1; i_raddr = 8'd3; i_we = 1'b1; i_waddr = 8'd3; i_wdata = 32'hFFFF_FFFF; i_wbe = 4'hF; end
      if (n == 50) begin i_re = 1'b0; i_we = 1'b0; end
    end
    chk("init_cycles_a", 32'(na), 32'd256);
    chk("init_cycles_b", 32'(nb), 32'd200);
    rdy = 1'b1;

    // cleared contents
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 128);
    drive(1, 0, 0, 0, 0, 1, 255);
    drive(1, 0, 0, 0, 0, 1, 3);
    idle(3);

    // byte-enable merge and read latency
    drive(1, 1, 5, 32'hAABB_CCDD, 4'b1111, 0, 0);
    drive(1, 1, 5, 32'h1122_3344, 4'b0101, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 5);
    @(posedge i_clk);
    #2;
    chk("lat_rvalid_a", {31'b0, rvalid_a}, 32'h1);
    chk("lat_rvalid_b", {31'b0, rvalid_b}, 32'h0);
    chk("be_merge_a", rdata_a, 32'hAA22_CC44);
    idle(1);
    @(posedge i_clk);
    #2;
    chk("lat2_rvalid_a", {31'b0, rvalid_a}, 32'h0);
    chk("lat2_rvalid_b", {31'b0, rvalid_b}, 32'h1);
    chk("be_merge_b", rdata_b, 32'hAA22_CC44);
    drive(1, 1, 5, 32'h5555_5555, 4'b0000, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 5);
    idle(3);

    // read-during-write to address 7
    drive(1, 1, 7, 32'hFFFF_FFFF, 4'b0011, 1, 7);
    @(posedge i_clk);
    #2;
    chk("rdw_read_first_a", rdata_a, 32'h0000_0000);
    idle(1);
    @(posedge i_clk);
    #2;
    chk("rdw_write_first_b", rdata_b, 32'h0000_FFFF);
    drive(1, 0, 0, 0, 0, 1, 7);
    idle(3);

    // stream of 8 reads with a 3-cycle i_ce gap
    for (int i = 0; i < 8; i++) drive(1, 1, i, 32'hA000_0000 + 32'(i) * 32'h0101_0101, 4'hF, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge i_clk);
          i_ce = 1'b0; i_we = 1'b1; i_waddr = 8'd6; i_wdata = 32'hDEAD_BEEF; i_wbe = 4'hF; i_re = 1'b1; i_raddr = 8'd99;
          @(posedge i_clk);
          #2;
          chk("freeze_rvalid_a", {31'b0, rvalid_a}, 32'h1);
          chk("freeze_rvalid_b", {31'b0, rvalid_b}, 32'h1);
          chk("freeze_rdata_a", rdata_a, last_a);
          chk("freeze_rdata_b", rdata_b, last_b);
        end
      end
      drive(1, 0, 0, 0, 0, 1, i);
    end
    idle(4);
    drive(1, 0, 0, 0, 0, 1, 6);
    idle(3);
    chk("stream_pending_a", 32'(qa.size()), 32'd0);
    chk("stream_pending_b", 32'(qb.size()), 32'd0);

    // out-of-range for the 200-deep instance
    drive(1, 1, 199, 32'h1234_5678, 4'hF, 0, 0);
    drive(1, 1, 210, 32'hCAFE_F00D, 4'hF, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 210);
    drive(1, 0, 0, 0, 0, 1, 199);
    idle(4);
    chk("oor_pending_a", 32'(qa.size()), 32'd0);
    chk("oor_pending_b", 32'(qb.size()), 32'd0);

    // asynchronous reset while results are in flight
    drive(1, 0, 0, 0, 0, 1, 5);
    drive(1, 0, 0, 0, 0, 1, 6);
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    rdy = 1'b0;
    #1;
    chk("async_rvalid_a", {31'b0, rvalid_a}, 32'h0);
    chk("async_rvalid_b", {31'b0, rvalid_b}, 32'h0);
    chk("async_rdata_a", rdata_a, 32'h0);
    chk("async_rdata_b", rdata_b, 32'h0);
    chk("async_done_a", {31'b0, done_a}, 32'h0);
    chk("async_done_b", {31'b0, done_b}, 32'h0);
    chk("async_drop_a", 32'(qa.size()), 32'd0);
    chk("async_drop_b", 32'(qb.size()), 32'd1);
    qb.delete();
    repeat (2) @(posedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
